bg_phase_mon: RTL

//  Receive-side monitor for the bandgap switch-phase bus driven by the bandgap controller.

---
 rtl/bg_pkg.sv | 17 +
 rtl/bg_phase_decode.sv | 28 ++
 rtl/bg_phase_mon.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bg_pkg.sv
// bg_pkg: switch-phase and monitor-state types plus the phase decode shared with controller assertions
package bg_pkg;
    typedef enum logic [3:0] {IDLE, PRE, DIODE_S, DIODE, BIG_S, BIG, HCHG, LCHG, OUT, ILLEGAL} phase_t;
    typedef enum logic [1:0] {WAIT_PRE, PRECHG, SETUP, RUN} mon_state_t;

    function automatic phase_t decode_phase(input logic pre, pi1, pi2, pii1, pii2, pa, pb, pc, pd);
        return pre                     ? PRE     :
               (pii1 & pii2)           ? DIODE   :
               pii1                    ? DIODE_S :
               (pi1 & pi2)             ? BIG     :
               pi1                     ? BIG_S   :
               (pa & pb & !pc)         ? HCHG    :
               (pa & pc & !pb)         ? LCHG    :
               (pb & pc & pd & !pa)    ? OUT     :
               !(pi1 | pi2 | pii1 | pii2 | pa | pb | pc | pd) ? IDLE : ILLEGAL;
    endfunction
endpackage

// File: rtl/bg_phase_decode.sv
// bg_phase_decode: combinational phase decode and per-cycle protocol violation flags
module bg_phase_decode
    import bg_pkg::*;
(
    input  logic   pi1,
    input  logic   pi2,
    input  logic   pii1,
    input  logic   pii2,
    input  logic   pa,
    input  logic   pb,
    input  logic   pc,
    input  logic   pd,
    input  logic   pre,
    input  logic   src_n,
    input  logic   snk,
    output phase_t phase,
    output logic   overlap,
    output logic   order,
    output logic   drive
);
    logic pi_any, pii_any;
    assign pi_any  = pi1 | pi2;
    assign pii_any = pii1 | pii2;
    assign phase   = decode_phase(pre, pi1, pi2, pii1, pii2, pa, pb, pc, pd);
    assign overlap = (pi_any & pii_any) | ((pa | pb | pc | pd) & (pi_any | pii_any));
    assign order   = (pi2 & ~pi1) | (pii2 & ~pii1);
    assign drive   = src_n & snk;
endmodule

// File: rtl/bg_phase_mon.sv
// bg_phase_mon: receive-side monitor of the bandgap switch-phase bus; tracks start-up,
// counts and times OUTPUT phases, flags protocol errors and reports cadence lock.
module bg_phase_mon
    import bg_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int PER_W  = 10,
    parameter int LOCK_N = 4,
    parameter int TOL    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             PI1,
    input  logic             PI2,
    input  logic             PII1,
    input  logic             PII2,
    input  logic             PA,
    input  logic             PB,
    input  logic             PC,
    input  logic             PD,
    input  logic             preChrg,
    input  logic             setupBias,
    input  logic             src_n,
    input  logic             snk,
    output phase_t           phase,
    output mon_state_t       mon_state,
    output logic             err_overlap,
    output logic             err_order,
    output logic             err_drive,
    output logic [CNT_W-1:0] out_cnt,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             locked
);
    localparam int SW = $clog2(LOCK_N + 1);

    phase_t           dec, phase_d;
    mon_state_t       state_nxt;
    logic             ov, od, dr, sb_q, have_ref;
    logic             chk, new_ov, new_od, new_dr, new_err;
    logic             restart, to_run, entry_out, upd, stable_ok;
    logic [PER_W-1:0] per_ctr, diff;
    logic [SW-1:0]    stable_cnt, stable_nxt;

    bg_phase_decode u_dec (
        .pi1(PI1), .pi2(PI2), .pii1(PII1), .pii2(PII2),
        .pa(PA), .pb(PB), .pc(PC), .pd(PD), .pre(preChrg),
        .src_n(src_n), .snk(snk),
        .phase(dec), .overlap(ov), .order(od), .drive(dr)
    );

    always_comb begin
        chk        = mon_state != WAIT_PRE;
        new_ov     = chk & ov;
        new_od     = chk & (od | (mon_state == RUN && dec == ILLEGAL));
        new_dr     = chk & dr;
        new_err    = new_ov | new_od | new_dr;
        state_nxt  = (mon_state == WAIT_PRE) ? ((phase == PRE) ? PRECHG : WAIT_PRE) :
                     (mon_state == PRECHG)   ? ((phase == DIODE_S) ? SETUP : PRECHG) :
                     (phase == PRE)          ? PRECHG :
                     (mon_state == SETUP && sb_q && !setupBias) ? RUN : mon_state;
        restart    = (mon_state == SETUP || mon_state == RUN) && state_nxt == PRECHG;
        to_run     = mon_state == SETUP && state_nxt == RUN;
        entry_out  = mon_state == RUN && phase == OUT && phase_d != OUT;
        upd        = entry_out && have_ref;
        diff       = (per_ctr > period) ? per_ctr - period : period - per_ctr;
        // a saturated period counter means the real gap is unknown, never stable
        stable_ok  = (per_ctr != '1) && (!period_vld || diff <= PER_W'(TOL));
        stable_nxt = !stable_ok ? '0 : (stable_cnt == SW'(LOCK_N)) ? stable_cnt : stable_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase       <= IDLE;
            phase_d     <= IDLE;
            mon_state   <= WAIT_PRE;
            sb_q        <= 1'b0;
            err_overlap <= 1'b0;
            err_order   <= 1'b0;
            err_drive   <= 1'b0;
            out_cnt     <= '0;
            period      <= '0;
            period_vld  <= 1'b0;
            locked      <= 1'b0;
            per_ctr     <= '0;
            have_ref    <= 1'b0;
            stable_cnt  <= '0;
        end else begin
            phase       <= dec;
            phase_d     <= phase;
            mon_state   <= state_nxt;
            sb_q        <= setupBias;
            err_overlap <= (err_overlap & ~clr) | new_ov;
            err_order   <= (err_order & ~clr) | new_od;
            err_drive   <= (err_drive & ~clr) | new_dr;
            per_ctr     <= entry_out ? PER_W'(1) : (per_ctr == '1) ? per_ctr : per_ctr + 1'b1;
            if (entry_out) begin
                have_ref <= 1'b1;
                out_cnt  <= (out_cnt == '1) ? out_cnt : out_cnt + 1'b1;
            end
            if (upd) begin
                period     <= per_ctr;
                period_vld <= 1'b1;
                stable_cnt <= stable_nxt;
                locked     <= stable_nxt == SW'(LOCK_N);
            end
            // later assignments deliberately override the update above
            if (restart || to_run)
                have_ref <= 1'b0;
            if (restart || to_run || clr)
                out_cnt <= '0;
            if (restart || clr)
                period_vld <= 1'b0;
            if (new_err || restart || to_run || clr) begin
                stable_cnt <= '0;
                locked     <= 1'b0;
            end
        end
    end
endmodule
